residue_packer: RTL
===================

RESIDUE_PACKER -- requirements
Module: residue_packer

Interface
REQ-001 The module SHALL have exactly one clock and one reset; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 valid_i  input  1  diff_i valid (upstream subtractor stage handshake).
REQ-005 ready_o  output  1  block can accept a new residue line.
REQ-006 diff_i  input  248  31 residue bytes; byte 0 = diff_i[247:240], byte 30 = diff_i[7:0].
REQ-007 valid_o  output  1  word_o valid.
REQ-008 ready_i  input  1  downstream accepts word_o.
REQ-009 word_o  output  32  packed output word.
REQ-010 last_o  output  1  word_o is the final word of the current line.
REQ-011 width_o  output  4  field width W of the line being emitted (0..8).

Function
REQ-012 Accept occurs on a rising edge with valid_i=1 and ready_o=1; diff_i SHALL be captured into an internal register at that edge.
REQ-013 FSM states: IDLE, ANALYZE, EMIT; ready_o SHALL be 1 only in IDLE (decoded from state register, no input-to-output path).
REQ-014 IDLE -> ANALYZE on accept; ANALYZE -> EMIT after exactly one cycle; EMIT -> IDLE on acceptance (valid_o & ready_i) of the word with last_o=1.
REQ-015 Byte width n(b): smallest n in 1..8 such that b equals its own low n bits sign-extended to 8 bits (0x00->1, 0xFF->1, 0x01->2, 0x3F->7, 0x7F->8, 0x80->8).
REQ-016 W SHALL be 0 if all 31 bytes are 0x00, else the maximum n(b) over the 31 bytes; W is computed in ANALYZE and registered for EMIT.
REQ-017 Packed stream, MSB-first: 4-bit header = W, then bytes 0..30 in order, each as its low W bits (no fields when W=0); total length L = 4 + 31*W bits.
REQ-018 Stream is emitted as N = ceil(L/32) words (1..8); word k carries stream bits 32k..32k+31 in word_o[31:0], MSB first; bits beyond L SHALL be 0.
REQ-019 First word SHALL be valid on the second cycle after the accept edge (accept at edge E, ANALYZE during cycle E+1, valid_o=1 from edge E+2).
REQ-020 In EMIT valid_o SHALL be 1 continuously; word_o, last_o and width_o SHALL be held stable while ready_i=0.
REQ-021 last_o SHALL be 1 only on word N-1; width_o SHALL equal W throughout EMIT and 0 otherwise.
REQ-022 valid_i asserted outside IDLE SHALL be ignored (no capture); upstream holds data until ready_o=1.
REQ-023 Word counter SHALL be 3 bits, reset to 0 on entry to EMIT, incremented only on valid_o & ready_i; no wrap beyond N-1.
REQ-024 Throughput: at most one line per N+2 cycles; no back-to-back accept in the last EMIT cycle.

Reset
REQ-025 When rst_n=0 at a rising edge: state SHALL become IDLE, word counter and W SHALL become 0, captured data SHALL be cleared.
REQ-026 Output values after reset: ready_o=1, valid_o=0, last_o=0, width_o=0, word_o=0x00000000.
REQ-027 Reset asserted mid-ANALYZE or mid-EMIT SHALL abandon the line; no further words for it are emitted.

Verification
REQ-028 All bytes 0x00, ready_i=1 -> W=0, one word 0x00000000 with last_o=1, valid_o at accept+2 cycles, ready_o=1 the cycle after.
REQ-029 All bytes 0xFF -> W=1, L=35, two words 0x1FFFFFFF then 0xE0000000 (last_o=1 on second).
REQ-030 Byte 0=0x80, others 0x00 -> W=8, eight words, word0=0x88000000, words1..7=0x00000000, last_o on word7.
REQ-031 All bytes 0x01 -> W=2, L=66, three words 0x25555555, 0x55555555, 0x40000000; ready_i held 0 for 3 cycles on word1 -> word_o stable, counter unchanged.
REQ-032 rst_n=0 for one cycle during word 3 of a W=8 line -> next cycle valid_o=0, ready_o=1, width_o=0; a new all-zero line then yields single word 0x00000000.

Source files
------------

// File: rtl/residue_packer.sv
// Residue packer: captures a 31-byte residue line, finds the common signed field
// width W, then streams {W, 31 x W-bit fields} MSB-first as 32-bit words.
module residue_packer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [247:0] diff_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [31:0]  word_o,
  output logic         last_o,
  output logic [3:0]   width_o,
  output logic [1:0]   dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid_o stays high and word_o/last_o/width_o stay stable until ready_i takes the word.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ANALYZE = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [247:0]       r_diff;
  logic [3:0]         r_width;
  logic [2:0]         r_cnt;

  logic [3:0]         w_width;
  logic [255:0]       w_stream;
  logic [7:0][31:0]   w_words;
  logic [2:0]         w_last_idx;
  logic               w_take;

  // Smallest n such that the byte is its own low n bits sign-extended.
  function automatic logic [3:0] byte_width(input logic [7:0] b);
    logic [7:0] m;
    logic [3:0] n;
    n = 4'd8;
    for (int k = 7; k >= 1; k--) begin
      m = 8'hFF << (k - 1);
      if (((b & m) == m) || ((b & m) == 8'h00)) n = 4'(k);
    end
    return n;
  endfunction

  always_comb begin
    logic [247:0] bytes;
    logic [3:0]   bw;
    w_width = 4'd0;
    bytes   = r_diff;
    for (int i = 0; i < 31; i++) begin
      bw = byte_width(bytes[247:240]);
      if (bw > w_width) w_width = bw;
      bytes = bytes << 8;
    end
    if (r_diff == 248'd0) w_width = 4'd0;
  end

  // Build the left-justified stream by shifting fields in; one arm per width.
  always_comb begin
    logic [255:0] acc;
    logic [247:0] bytes;
    logic [7:0]   mask;
    w_stream = '0;
    acc      = '0;
    bytes    = '0;
    mask     = '0;
    for (int w = 1; w <= 8; w++) begin
      if (r_width == 4'(w)) begin
        acc   = 256'(r_width);
        bytes = r_diff;
        mask  = 8'hFF >> (8 - w);
        for (int i = 0; i < 31; i++) begin
          acc   = (acc << w) | 256'(bytes[247:240] & mask);
          bytes = bytes << 8;
        end
        w_stream = acc << (252 - 31 * w);
      end
    end
  end

  assign w_words = w_stream;

  always_comb begin
    case (r_width)
      4'd0:    w_last_idx = 3'd0;
      4'd1:    w_last_idx = 3'd1;
      4'd2:    w_last_idx = 3'd2;
      4'd3:    w_last_idx = 3'd3;
      4'd4:    w_last_idx = 3'd3;
      4'd5:    w_last_idx = 3'd4;
      4'd6:    w_last_idx = 3'd5;
      4'd7:    w_last_idx = 3'd6;
      default: w_last_idx = 3'd7;
    endcase
  end

  assign w_take = (r_state == S_EMIT) && ready_i;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (valid_i) w_next = S_ANALYZE;
      S_ANALYZE: w_next = S_EMIT;
      S_EMIT:    if (w_take && (r_cnt == w_last_idx)) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_diff  <= '0;
      r_width <= 4'd0;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && valid_i) r_diff <= diff_i;
      if (r_state == S_ANALYZE) begin
        r_width <= w_width;
        r_cnt   <= 3'd0;
      end
      if (w_take && (r_cnt != w_last_idx)) r_cnt <= r_cnt + 3'd1;
    end
  end

  assign ready_o     = (r_state == S_IDLE);
  assign valid_o     = (r_state == S_EMIT);
  assign word_o      = (r_state == S_EMIT) ? w_words[3'd7 - r_cnt] : 32'd0;
  assign last_o      = (r_state == S_EMIT) && (r_cnt == w_last_idx);
  assign width_o     = (r_state == S_EMIT) ? r_width : 4'd0;
  assign dbg_state_o = r_state;

endmodule
